cordic_post_processing_unit: RTL

- Output-side counterpart of the CORDIC pre-processing (range-reduction) unit.
- Queues the per-angle Cos_negate/Sin_negate quadrant flags issued alongside each reduced angle, then pairs them in order with first-quadrant cos/sin results returning from the iterative core.
- Applies saturating sign correction and presents final cos/sin on a registered valid/ready output.
- Sits between the CORDIC core result port and the downstream consumer.

---
 rtl/cordic_post_processing_unit_pkg.sv | 35 +++
 rtl/cordic_flag_fifo.sv | 61 ++++++
 rtl/cordic_post_processing_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/cordic_post_processing_unit_pkg.sv
// Shared CORDIC definitions: data width, Q2.14 angle constants, quadrant flags
// and the saturating negate used for output sign correction.
package cordic_post_processing_unit_pkg;

  localparam int unsigned CORDIC_DATA_W = 16;

  // Q2.14 angle constants used by range reduction; they exceed the signed data
  // range, so they are kept as unsigned integers.
  localparam int unsigned PI_2   = 25736;
  localparam int unsigned PI     = 51472;
  localparam int unsigned PI_3_2 = 77208;
  localparam int unsigned TWO_PI = 102944;

  typedef logic signed [CORDIC_DATA_W-1:0] data_t;

  typedef struct packed {
    logic cos_neg;
    logic sin_neg;
  } quad_flag_t;

  typedef struct packed {
    logic  sat;
    data_t val;
  } neg_t;

  // -x, except the most negative code maps to the most positive one.
  function automatic neg_t sneg(input data_t x);
    neg_t r;
    r.sat = (x == data_t'({1'b1, {(CORDIC_DATA_W-1){1'b0}}}));
    if (r.sat) r.val = data_t'({1'b0, {(CORDIC_DATA_W-1){1'b1}}});
    else       r.val = -x;
    return r;
  endfunction

endpackage

// File: rtl/cordic_flag_fifo.sv
// Circular synchronous FIFO with occupancy count; no read-through bypass,
// synchronous clear takes priority over push and pop.
module cordic_flag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full_c && !i_clr;
  assign w_pop     = i_pop && !o_empty_c && !i_clr;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/cordic_post_processing_unit.sv
// Pairs queued quadrant flags with first-quadrant CORDIC results and applies
// saturating sign correction into a registered valid/ready output stage.
module cordic_post_processing_unit
  import cordic_post_processing_unit_pkg::*;
#(
  parameter int unsigned DATA_W = CORDIC_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_flag_valid,
  input  logic              i_cos_negate,
  input  logic              i_sin_negate,
  output logic              o_flag_ready_c,
  input  logic              i_core_valid,
  input  logic [DATA_W-1:0] i_core_cos,
  input  logic [DATA_W-1:0] i_core_sin,
  output logic              o_core_ready_c,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_cos,
  output logic [DATA_W-1:0] o_out_sin,
  output logic              o_out_sat,
  input  logic              i_out_ready,
  output logic [CNT_W-1:0]  o_flag_count,
  output logic              o_err_orphan
);

  quad_flag_t        w_wr_flag;
  quad_flag_t        w_rd_flag;
  logic              w_full;
  logic              w_empty;
  logic              w_can_load;
  logic              w_pop;
  neg_t              w_cos_neg;
  neg_t              w_sin_neg;
  logic [DATA_W-1:0] w_cos_res;
  logic [DATA_W-1:0] w_sin_res;
  logic              w_sat;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_cos;
  logic [DATA_W-1:0] r_out_sin;
  logic              r_out_sat;
  logic              r_err_orphan;

  assign w_wr_flag = '{cos_neg: i_cos_negate, sin_neg: i_sin_negate};

  cordic_flag_fifo #(
    .WIDTH ($bits(quad_flag_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_flag_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_flush),
    .i_push    (i_flag_valid),
    .i_wdata   (w_wr_flag),
    .i_pop     (w_pop),
    .o_rdata_c (w_rd_flag),
    .o_count   (o_flag_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // A result is taken only when a flag is waiting and the output can accept it.
  assign w_can_load     = !r_out_valid || i_out_ready;
  assign o_core_ready_c = !w_empty && w_can_load && !i_flush;
  assign o_flag_ready_c = !w_full;
  assign w_pop          = i_core_valid && o_core_ready_c;

  assign w_cos_neg = sneg(data_t'(i_core_cos));
  assign w_sin_neg = sneg(data_t'(i_core_sin));
  assign w_cos_res = w_rd_flag.cos_neg ? DATA_W'(w_cos_neg.val) : i_core_cos;
  assign w_sin_res = w_rd_flag.sin_neg ? DATA_W'(w_sin_neg.val) : i_core_sin;
  assign w_sat     = (w_rd_flag.cos_neg && w_cos_neg.sat) ||
                     (w_rd_flag.sin_neg && w_sin_neg.sat);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_cos   <= '0;
      r_out_sin   <= '0;
      r_out_sat   <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_cos   <= w_cos_res;
      r_out_sin   <= w_sin_res;
      r_out_sat   <= w_sat;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky record of a core result arriving with no flag to pair it with.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_err_orphan <= 1'b0;
    else if (i_core_valid && w_empty) r_err_orphan <= 1'b1;
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_cos    = r_out_cos;
  assign o_out_sin    = r_out_sin;
  assign o_out_sat    = r_out_sat;
  assign o_err_orphan = r_err_orphan;

endmodule
